// File: rtl/pwm_generator_pkg.sv
// Shared definitions for the PWM generator slice.
// Holds the dead-time FSM state encoding, default parameter values and
// a helper that sizes the prescaler counter.
package pwm_generator_pkg;

    localparam int PWM_WIDTH_DEFAULT  = 8;
    localparam int DEAD_WIDTH_DEFAULT = 4;
    localparam int PRESCALE_DEFAULT   = 1;

    // Dead-time insertion states:
    //   DT_ACTIVE - the side matching raw is driven
    //   DT_WAIT   - both sides held low while the dead counter runs
    typedef enum logic {
        DT_ACTIVE = 1'b0,
        DT_WAIT   = 1'b1
    } dt_state_e;

    // Prescaler counter width; a PRESCALE of 1 still gets a 1-bit register
    // so the tick logic needs no special case.
    function automatic int presc_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_generator_dead_time_insert.sv
// Dead-time insertion for a complementary H/L output pair.
// Ports: clk, rst (async, active high), raw (PWM level), dead_in (dead time
// in clk cycles), pwm_h / pwm_l (registered outputs, never both high).
module dead_time_insert
    import pwm_generator_pkg::*;
#(
    parameter int DEAD_WIDTH = DEAD_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  raw,
    input  logic [DEAD_WIDTH-1:0] dead_in,
    output logic                  pwm_h,
    output logic                  pwm_l
);

    dt_state_e             r_state;
    dt_state_e             w_state_nxt;
    logic                  r_raw_d;
    logic [DEAD_WIDTH-1:0] r_dcnt;
    logic [DEAD_WIDTH-1:0] w_dcnt_nxt;
    logic                  r_h;
    logic                  r_l;
    logic                  w_h_nxt;
    logic                  w_l_nxt;
    logic                  w_edge;

    assign w_edge = raw ^ r_raw_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DT_ACTIVE;
            r_raw_d <= 1'b0;
            r_dcnt  <= '0;
            r_h     <= 1'b0;
            r_l     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_raw_d <= raw;
            r_dcnt  <= w_dcnt_nxt;
            r_h     <= w_h_nxt;
            r_l     <= w_l_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_h_nxt     = r_h;
        w_l_nxt     = r_l;

        if (w_edge) begin
            // Every raw edge restarts the blanking interval, including edges
            // that arrive while a previous interval is still running.
            if (dead_in == '0) begin
                w_h_nxt     = raw;
                w_l_nxt     = ~raw;
                w_state_nxt = DT_ACTIVE;
            end else begin
                w_h_nxt     = 1'b0;
                w_l_nxt     = 1'b0;
                w_dcnt_nxt  = dead_in;
                w_state_nxt = DT_WAIT;
            end
        end else begin
            case (r_state)
                DT_ACTIVE: begin
                    w_h_nxt = raw;
                    w_l_nxt = ~raw;
                end
                DT_WAIT: begin
                    // The counter is loaded with dead_in on the edge clock, so
                    // expiring at 1 gives exactly dead_in low cycles.
                    if (r_dcnt == DEAD_WIDTH'(1)) begin
                        w_h_nxt     = raw;
                        w_l_nxt     = ~raw;
                        w_state_nxt = DT_ACTIVE;
                    end else begin
                        w_h_nxt    = 1'b0;
                        w_l_nxt    = 1'b0;
                        w_dcnt_nxt = r_dcnt - DEAD_WIDTH'(1);
                    end
                end
                default: begin
                    w_h_nxt     = 1'b0;
                    w_l_nxt     = 1'b0;
                    w_state_nxt = DT_ACTIVE;
                end
            endcase
        end
    end

    assign pwm_h = r_h;
    assign pwm_l = r_l;

endmodule

// File: rtl/pwm_generator.sv
// Edge-aligned PWM with double-buffered period/duty and dead-time insertion.
// Ports: clk, rst (async, active high), enable, period_in (period-1 in ticks),
// duty_in (high ticks), dead_in (dead clks), pwm_h, pwm_l, period_last.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int WIDTH      = PWM_WIDTH_DEFAULT,
    parameter int DEAD_WIDTH = DEAD_WIDTH_DEFAULT,
    parameter int PRESCALE   = PRESCALE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      period_in,
    input  logic [WIDTH-1:0]      duty_in,
    input  logic [DEAD_WIDTH-1:0] dead_in,
    output logic                  pwm_h,
    output logic                  pwm_l,
    output logic                  period_last
);

    localparam int PS_W = presc_bits(PRESCALE);

    logic [PS_W-1:0]  r_presc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_duty;
    logic             r_period_last;
    logic             r_raw;
    logic             w_tick;
    logic             w_wrap;
    logic             w_dt_h;
    logic             w_dt_l;

    // With PRESCALE=1 the prescaler never leaves 0, so tick reduces to enable.
    assign w_tick = enable && (r_presc == PS_W'(PRESCALE - 1));
    assign w_wrap = (r_cnt == r_period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (!enable || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PS_W'(1);
        end
    end

    // Period counter and shadow registers. Shadows track the inputs freely
    // while stopped so the first period after enable uses current settings,
    // and otherwise update only on the wrap tick for glitch-free edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_period      <= '0;
            r_duty        <= '0;
            r_period_last <= 1'b0;
        end else if (!enable) begin
            r_cnt         <= '0;
            r_period      <= period_in;
            r_duty        <= duty_in;
            r_period_last <= 1'b0;
        end else begin
            r_period_last <= w_tick && w_wrap;
            if (w_tick) begin
                if (w_wrap) begin
                    r_cnt    <= '0;
                    r_period <= period_in;
                    r_duty   <= duty_in;
                end else begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end
    end

    // Duty compare. duty > period naturally gives 100% because cnt never
    // exceeds period; duty = 0 never compares true.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw <= 1'b0;
        end else begin
            r_raw <= (r_cnt < r_duty);
        end
    end

    dead_time_insert #(
        .DEAD_WIDTH (DEAD_WIDTH)
    ) u_dead_time (
        .clk     (clk),
        .rst     (rst),
        .raw     (r_raw),
        .dead_in (dead_in),
        .pwm_h   (w_dt_h),
        .pwm_l   (w_dt_l)
    );

    // The dead-time stage keeps tracking raw while stopped; enable masks both
    // switches off immediately so a stopped bridge is always fully off.
    assign pwm_h       = w_dt_h & enable;
    assign pwm_l       = w_dt_l & enable;
    assign period_last = r_period_last;

endmodule
